// File: rtl/video_pattern_pkg.sv
// Shared definitions for the parametrised video test pattern generator:
// pattern mode encodings, the colour bar table and a counter-width helper.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam int NUM_BARS = 8;

  // Bar colours as {R,G,B} on/off flags, left to right across the line.
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;  // white
      3'd1:    return 3'b110;  // yellow
      3'd2:    return 3'b011;  // cyan
      3'd3:    return 3'b010;  // green
      3'd4:    return 3'b101;  // magenta
      3'd5:    return 3'b100;  // red
      3'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

  // Bits needed to hold any value in 0..max_val (never less than 1).
  function automatic int count_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster timing: h/v counters, sync and data-enable decode, idle handling
// and the end-of-line / end-of-frame strobes. Decodes are combinational.
module video_timing_core
  import video_pattern_pkg::*;
#(
  parameter  int H_ACTIVE = 1920,
  parameter  int H_FP     = 88,
  parameter  int H_SYNC   = 44,
  parameter  int H_BP     = 148,
  parameter  int V_ACTIVE = 1080,
  parameter  int V_FP     = 4,
  parameter  int V_SYNC   = 5,
  parameter  int V_BP     = 36,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = count_width(H_TOTAL),
  localparam int VW       = count_width(V_TOTAL)
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          line_end,
  output logic          frame_wrap
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
    $error("video_timing_core: H_TOTAL and V_TOTAL must both be at least 2");
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign line_end   = (h == H_LAST);
  assign frame_wrap = line_end && (v == V_LAST);
  assign active     = (h < H_ACT) && (v < V_ACT);
  assign hsync_on   = (h >= HS_BEGIN) && (h < HS_END);
  assign vsync_on   = (v >= VS_BEGIN) && (v < VS_END);

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised DVI/HDMI test pattern generator: raster timing plus four
// frame-synchronous patterns, all outputs registered one cycle after timing.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1,
  parameter int BPC      = 8,
  parameter int CHK_LOG2 = 5
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3*BPC-1:0] solid_rgb,
  output logic             video_hsync,
  output logic             video_vsync,
  output logic             video_den,
  output logic [3*BPC-1:0] video_pixel,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW       = count_width(H_TOTAL);
  localparam int   VW       = count_width(V_TOTAL);
  localparam int   BAR_W    = (H_ACTIVE / NUM_BARS < 1) ? 1 : H_ACTIVE / NUM_BARS;
  localparam int   BW       = count_width(BAR_W);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  if (CHK_LOG2 < 0 || CHK_LOG2 >= HW || CHK_LOG2 >= VW || BPC < 1) begin : g_bad_param
    $error("video_pattern_gen: CHK_LOG2 must index inside both counters, BPC >= 1");
  end

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             active, hsync_on, vsync_on, line_end, frame_wrap;
  mode_e            mode_q;
  logic [3*BPC-1:0] solid_q;
  logic [BW-1:0]    bar_pos;
  logic [2:0]       bar_idx;
  logic [2:0]       flags;
  logic [BPC-1:0]   ramp;
  logic [3*BPC-1:0] pattern;

  video_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (enable),
    .h           (h),
    .v           (v),
    .active      (active),
    .hsync_on    (hsync_on),
    .vsync_on    (vsync_on),
    .line_end    (line_end),
    .frame_wrap  (frame_wrap)
  );

  // Bar index tracks h by counting BAR_W-pixel segments; it saturates on the
  // last bar so that bar absorbs any remainder of H_ACTIVE.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (!enable || line_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BAR_LAST) begin
      bar_pos <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  assign flags = bar_flags(bar_idx);
  assign ramp  = BPC'(h) + BPC'(frame_count);

  // NOTE: pattern gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_BARS:  pattern = {{BPC{flags[2]}}, {BPC{flags[1]}}, {BPC{flags[0]}}};
      MODE_RAMP:  pattern = {3{ramp}};
      MODE_CHECK: pattern = (h[CHK_LOG2] ^ v[CHK_LOG2]) ? '1 : '0;
      MODE_SOLID: pattern = solid_q;
    endcase
  end

  // Output stage; mode and colour are only sampled while idle or on the
  // frame wrap so a frame never mixes two patterns.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      video_den   <= 1'b0;
      video_hsync <= SYNC_OFF;
      video_vsync <= SYNC_OFF;
      video_pixel <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      mode_q      <= MODE_BARS;
      solid_q     <= '0;
    end else if (!enable) begin
      video_den   <= 1'b0;
      video_hsync <= SYNC_OFF;
      video_vsync <= SYNC_OFF;
      video_pixel <= '0;
      frame_start <= 1'b0;
      mode_q      <= mode_e'(mode);
      solid_q     <= solid_rgb;
    end else begin
      video_den   <= active;
      video_hsync <= hsync_on ? SYNC_ON : SYNC_OFF;
      video_vsync <= vsync_on ? SYNC_ON : SYNC_OFF;
      video_pixel <= active ? pattern : '0;
      frame_start <= (h == '0) && (v == '0);
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
        mode_q      <= mode_e'(mode);
        solid_q     <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised self-checking bench for video_pattern_gen on a small 24x7 raster,
// compared cycle by cycle against a frame-position reference model.
module tb_video_pattern_gen;

  localparam int H_ACT = 16, H_TOT = 24, V_ACT = 4, V_TOT = 7;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int BAR_W = 2;

  logic        pixel_clock;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        video_hsync, video_vsync, video_den, frame_start;
  logic [23:0] video_pixel;
  logic [15:0] frame_count;

  video_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1),  .BPC (8),  .CHK_LOG2 (2)
  ) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .video_hsync (video_hsync),
    .video_vsync (video_vsync),
    .video_den   (video_den),
    .video_pixel (video_pixel),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: position inside the frame as a single index.
  int          m_pos;
  logic [15:0] m_fc;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic        e_den, e_hs, e_vs, e_fs;
  logic [23:0] e_pix;

  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] ref_pixel(input int x, input int y, input logic [1:0] md,
                                            input logic [23:0] sd, input logic [15:0] fc);
    int idx, g;
    if (!(x < H_ACT && y < V_ACT)) return 24'h0;
    case (md)
      2'd0: begin
        idx = x / BAR_W;
        if (idx > 7) idx = 7;
        return BAR_RGB[idx];
      end
      2'd1: begin
        g = (x + int'(fc)) % 256;
        return {g[7:0], g[7:0], g[7:0]};
      end
      2'd2: return (((x / 4) + (y / 4)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: return sd;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_fc = '0; m_mode = '0; m_solid = '0;
    e_den = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_pix = '0;
  endtask

  task automatic model_step(input logic en, input logic [1:0] md, input logic [23:0] sd);
    int x, y;
    if (reset) begin
      model_reset();
    end else if (!en) begin
      e_den = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_pix = '0;
      m_pos = 0; m_mode = md; m_solid = sd;
    end else begin
      x = m_pos % H_TOT;
      y = m_pos / H_TOT;
      e_den = (x < H_ACT) && (y < V_ACT);
      e_hs  = (x >= 18) && (x < 21);
      e_vs  = (y == 5);
      e_fs  = (m_pos == 0);
      e_pix = ref_pixel(x, y, m_mode, m_solid, m_fc);
      if (m_pos == FRAME - 1) begin
        m_fc = m_fc + 16'd1; m_mode = md; m_solid = sd;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic compare_all();
    check("den",   video_den,   e_den);
    check("hsync", video_hsync, e_hs);
    check("vsync", video_vsync, e_vs);
    check("pixel", video_pixel, e_pix);
    check("frame_start", frame_start, e_fs);
    check("frame_count", frame_count, m_fc);
  endtask

  task automatic cycle(input logic en, input logic [1:0] md, input logic [23:0] sd);
    enable = en; mode = md; solid_rgb = sd;
    @(posedge pixel_clock);
    model_step(en, md, sd);
    #1;
    compare_all();
  endtask

  task automatic advance_to(input int target, input logic en, input logic [1:0] md,
                            input logic [23:0] sd);
    int guard = 0;
    while (m_pos != target && guard < 2 * FRAME) begin
      cycle(en, md, sd);
      guard++;
    end
  endtask

  initial begin
    int fs_q[$];
    logic [15:0] saved_fc;
    logic        r_en;
    logic [1:0]  r_md;
    logic [23:0] r_sd;

    reset = 1; enable = 0; mode = 0; solid_rgb = '0;
    model_reset();
    repeat (2) cycle(0, 2'd0, 24'h0);
    reset = 0;
    repeat (3) cycle(0, 2'd0, 24'h0);

    // Bars, frame timing and frame length.
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1, 2'd0, 24'h0);
      if (frame_start) fs_q.push_back(i);
    end
    check("fs_pulses", fs_q.size(), 2);
    if (fs_q.size() >= 2) begin
      check("fs_first", fs_q[0], 0);
      check("frame_len", fs_q[1] - fs_q[0], FRAME);
    end

    // Ramp over several frames; takes effect at the next wrap.
    for (int i = 0; i < 4 * FRAME; i++) cycle(1, 2'd1, 24'h0);
    check("fc_after_ramp", frame_count, 16'd6);

    // Bars frame, switched to checker at (h=5, v=1).
    advance_to(0, 1, 2'd0, 24'h0);
    advance_to(H_TOT + 5, 1, 2'd0, 24'h0);
    for (int i = 0; i < 2 * FRAME; i++) cycle(1, 2'd2, 24'h0);

    // Solid colour changed mid-frame.
    advance_to(0, 1, 2'd3, 24'h123456);
    advance_to(80, 1, 2'd3, 24'h123456);
    for (int i = 0; i < FRAME + 40; i++) cycle(1, 2'd3, 24'hABCDEF);

    // Enable dropped at (h=10, v=2) for 5 cycles.
    advance_to(2 * H_TOT + 10, 1, 2'd3, 24'hABCDEF);
    saved_fc = frame_count;
    repeat (5) cycle(0, 2'd1, 24'h0);
    cycle(1, 2'd1, 24'h0);
    check("reenable_fs", frame_start, 1'b1);
    check("reenable_fc", frame_count, saved_fc);
    for (int i = 0; i < FRAME; i++) cycle(1, 2'd1, 24'h0);

    // Random traffic.
    r_en = 1; r_md = 2'd0; r_sd = 24'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) r_md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) r_sd = 24'($urandom);
      if (r_en ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 7) == 0)) r_en = ~r_en;
      cycle(r_en, r_md, r_sd);
    end

    // Asynchronous reset in the middle of an active line.
    advance_to(H_TOT + 7, 1, 2'd0, 24'h0);
    #2 reset = 1;
    #1;
    model_reset();
    check("arst_den", video_den, 1'b0);
    check("arst_hsync", video_hsync, 1'b0);
    check("arst_vsync", video_vsync, 1'b0);
    check("arst_pixel", video_pixel, 24'h0);
    check("arst_fs", frame_start, 1'b0);
    check("arst_fc", frame_count, 16'h0);
    cycle(1, 2'd0, 24'h0);
    reset = 0;
    repeat (2) cycle(0, 2'd2, 24'h0);
    for (int i = 0; i < FRAME + 10; i++) cycle(1, 2'd2, 24'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
